// File: rtl/cell_extremum.sv
// Streaming per-channel max/min reducer: one result per cell of CELL_LEN valid samples.
// Optional winner-index output is enabled by defining CELL_EXTREMUM_INDEX_EN.
module cell_extremum #(
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned CH_WIDTH = 8,
  parameter int unsigned CELL_LEN = 24
) (
  input  logic                           clkn,
  input  logic                           reset,
  input  logic                           mode,
  input  logic                           clear,
  input  logic                           valid_in,
  input  logic [CHANNELS*CH_WIDTH-1:0]   data_in,
  output logic                           valid_out,
  output logic [CHANNELS*CH_WIDTH-1:0]   data_out,
  output logic                           busy
`ifdef CELL_EXTREMUM_INDEX_EN
  ,
  output logic [CHANNELS*$clog2(CELL_LEN)-1:0] index_out
`endif
);

  localparam int unsigned DW = CHANNELS * CH_WIDTH;
  localparam int unsigned IW = $clog2(CELL_LEN);
  localparam logic [IW-1:0] LAST = IW'(CELL_LEN - 1);

  logic [IW-1:0] r_cnt;
  logic [DW-1:0] r_acc;
  logic          r_mode;
  logic          r_valid_out;
  logic [DW-1:0] r_data_out;
  logic          r_busy;

  logic          w_first;
  logic          w_last;
  logic          w_mode;
  logic [DW-1:0] w_comb;
  logic [IW-1:0] w_cnt_nxt;

`ifdef CELL_EXTREMUM_INDEX_EN
  logic [CHANNELS*IW-1:0] r_idx;
  logic [CHANNELS*IW-1:0] r_index_out;
  logic [CHANNELS*IW-1:0] w_idx;
`endif

  // A clear turns the concurrent sample into sample 0 and blocks completion.
  assign w_first = clear || (r_cnt == '0);
  assign w_last  = !clear && (r_cnt == LAST);
  assign w_mode  = w_first ? mode : r_mode;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [CH_WIDTH-1:0] w_d;
    logic [CH_WIDTH-1:0] w_a;
    logic                w_take;

    assign w_d    = data_in[c*CH_WIDTH +: CH_WIDTH];
    assign w_a    = r_acc[c*CH_WIDTH +: CH_WIDTH];
    // Strict compare keeps the earliest sample on ties.
    assign w_take = w_first || (w_mode ? (w_d < w_a) : (w_d > w_a));
    assign w_comb[c*CH_WIDTH +: CH_WIDTH] = w_take ? w_d : w_a;
`ifdef CELL_EXTREMUM_INDEX_EN
    assign w_idx[c*IW +: IW] = w_first ? '0 : (w_take ? r_cnt : r_idx[c*IW +: IW]);
`endif
  end

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (valid_in) begin
      if (w_first)     w_cnt_nxt = IW'(1);
      else if (w_last) w_cnt_nxt = '0;
      else             w_cnt_nxt = r_cnt + IW'(1);
    end else if (clear) begin
      w_cnt_nxt = '0;
    end
  end

  always_ff @(negedge clkn) begin
    if (reset) begin
      r_cnt       <= '0;
      r_acc       <= '0;
      r_mode      <= 1'b0;
      r_valid_out <= 1'b0;
      r_data_out  <= '0;
      r_busy      <= 1'b0;
`ifdef CELL_EXTREMUM_INDEX_EN
      r_idx       <= '0;
      r_index_out <= '0;
`endif
    end else begin
      r_valid_out <= 1'b0;
      r_cnt       <= w_cnt_nxt;
      r_busy      <= (w_cnt_nxt != '0);
      if (valid_in) begin
        if (w_last) begin
          r_valid_out <= 1'b1;
          r_data_out  <= w_comb;
`ifdef CELL_EXTREMUM_INDEX_EN
          r_index_out <= w_idx;
`endif
        end else begin
          r_acc  <= w_comb;
          r_mode <= w_mode;
`ifdef CELL_EXTREMUM_INDEX_EN
          r_idx  <= w_idx;
`endif
        end
      end
    end
  end

  assign valid_out = r_valid_out;
  assign data_out  = r_data_out;
  assign busy      = r_busy;
`ifdef CELL_EXTREMUM_INDEX_EN
  assign index_out = r_index_out;
`endif

endmodule
